// File: rtl/spu_ldst_arb_if.sv
// SPU -> LSU ld/st packet channel bundle.
// Requester side, grant pulses and the LSU packet/ack path.
interface spu_ldst_arb_if #(
    parameter int NREQ = 4,
    parameter int PW   = 123
);
    logic [NREQ-1:0]    req_vld;
    logic [NREQ*PW-1:0] req_pckt;
    logic [NREQ-1:0]    arb_grant;
    logic               ldst_pckt_vld;
    logic [PW-1:0]      ldst_pckt;
    logic               lsu_ldst_ack;

    modport master (
        input  req_vld, req_pckt, lsu_ldst_ack,
        output arb_grant, ldst_pckt_vld, ldst_pckt
    );

    modport slave (
        output req_vld, req_pckt, lsu_ldst_ack,
        input  arb_grant, ldst_pckt_vld, ldst_pckt
    );
endinterface

// File: rtl/spu_ldst_arb.sv
// Round-robin SPU ld/st packet arbiter with credit-limited
// outstanding count, holding each packet until LSU ack.
module spu_ldst_arb #(
    parameter int NREQ      = 4,
    parameter int PW        = 123,
    parameter int MAX_OUTST = 8,
    parameter int CNTW      = 4
) (
    input  logic            rclk,
    input  logic            arst_l,
    spu_ldst_arb_if.master  bus,
    input  logic            cpx_rtn_vld,
    output logic [CNTW-1:0] outst_cnt,
    output logic            arb_busy,
    output logic            rtn_err
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   last, last_nxt;
    logic [IW-1:0]   win_idx, cand;
    logic            win_vld;
    logic            can_grant;
    logic            acc_ack;
    logic [NREQ-1:0] grant_q, grant_nxt;
    logic            vld_q, vld_nxt;
    logic [PW-1:0]   pckt_q, pckt_nxt;
    logic [CNTW-1:0] cnt_q, cnt_nxt;
    logic            err_q, err_nxt;

    // first valid requester scanning upward from last+1
    always_comb begin
        win_vld = 1'b0;
        win_idx = last;
        cand    = last;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last) + k) % NREQ);
            if (!win_vld && bus.req_vld[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign can_grant = (state == IDLE) && win_vld &&
                       (cnt_q < CNTW'(MAX_OUTST));
    assign acc_ack   = (state == SEND) && bus.lsu_ldst_ack;

    // state register
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) state <= IDLE;
        else         state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (can_grant) state_nxt = SEND;
            SEND: if (bus.lsu_ldst_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // next values for the registered outputs and the credit count
    always_comb begin
        grant_nxt = '0;
        vld_nxt   = vld_q;
        pckt_nxt  = pckt_q;
        last_nxt  = last;
        cnt_nxt   = cnt_q;
        err_nxt   = 1'b0;
        if (can_grant) begin
            grant_nxt = NREQ'(1) << win_idx;
            vld_nxt   = 1'b1;
            pckt_nxt  = bus.req_pckt[int'(win_idx)*PW +: PW];
            last_nxt  = win_idx;
        end
        if (acc_ack) vld_nxt = 1'b0;
        unique case (1'b1)
            acc_ack && !cpx_rtn_vld:
                cnt_nxt = cnt_q + CNTW'(1);
            !acc_ack && cpx_rtn_vld && (cnt_q != '0):
                cnt_nxt = cnt_q - CNTW'(1);
            !acc_ack && cpx_rtn_vld && (cnt_q == '0):
                err_nxt = 1'b1;
            default: cnt_nxt = cnt_q;
        endcase
    end

    // output and pointer registers
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            grant_q <= '0;
            vld_q   <= 1'b0;
            pckt_q  <= '0;
            last    <= IW'(NREQ - 1);
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            grant_q <= grant_nxt;
            vld_q   <= vld_nxt;
            pckt_q  <= pckt_nxt;
            last    <= last_nxt;
            cnt_q   <= cnt_nxt;
            err_q   <= err_nxt;
        end
    end

    assign bus.arb_grant     = grant_q;
    assign bus.ldst_pckt_vld = vld_q;
    assign bus.ldst_pckt     = pckt_q;
    assign outst_cnt         = cnt_q;
    assign rtn_err           = err_q;
    assign arb_busy          = (state == SEND);
endmodule

// File: tb/tb_spu_ldst_arb.sv
// Directed vector bench for spu_ldst_arb.
// Table vectors plus hand sequences for full, hold and reset.
module tb_spu_ldst_arb;
    localparam int NREQ = 4;
    localparam int PW   = 123;

    logic       clk = 1'b0;
    logic       arst_l;
    logic       cpx_rtn_vld;
    logic [3:0] outst_cnt;
    logic       arb_busy;
    logic       rtn_err;

    int n_vec = 0;
    int n_bad = 0;

    logic [PW-1:0] pk [5];

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic       ack;
        logic       rtn;
        logic [3:0] g;
        logic       v;
        int         p;
        logic [3:0] c;
        logic       b;
        logic       e;
    } vec_t;

    vec_t tv [26];

    spu_ldst_arb_if #(.NREQ(NREQ), .PW(PW)) bus ();

    spu_ldst_arb #(
        .NREQ(NREQ), .PW(PW), .MAX_OUTST(8), .CNTW(4)
    ) dut (
        .rclk       (clk),
        .arst_l     (arst_l),
        .bus        (bus),
        .cpx_rtn_vld(cpx_rtn_vld),
        .outst_cnt  (outst_cnt),
        .arb_busy   (arb_busy),
        .rtn_err    (rtn_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst_l = 1'b0;
        #2;
        arst_l = 1'b1;
    endtask

    task automatic drive_pk();
        bus.req_pckt = {pk[3], pk[2], pk[1], pk[0]};
    endtask

    task automatic chk(input string nm, input logic [3:0] g,
                       input logic v, input int p,
                       input logic [3:0] c, input logic b,
                       input logic e);
        bit bad;
        bad = 1'b0;
        n_vec++;
        if (bus.arb_grant !== g) begin
            $display("FAIL %s grant got %b want %b", nm,
                     bus.arb_grant, g);
            bad = 1'b1;
        end
        if (bus.ldst_pckt_vld !== v) begin
            $display("FAIL %s vld got %b want %b", nm,
                     bus.ldst_pckt_vld, v);
            bad = 1'b1;
        end
        if (bus.ldst_pckt !== pk[p]) begin
            $display("FAIL %s pckt got %h want %h", nm,
                     bus.ldst_pckt, pk[p]);
            bad = 1'b1;
        end
        if (outst_cnt !== c) begin
            $display("FAIL %s cnt got %0d want %0d", nm,
                     outst_cnt, c);
            bad = 1'b1;
        end
        if (arb_busy !== b) begin
            $display("FAIL %s busy got %b want %b", nm,
                     arb_busy, b);
            bad = 1'b1;
        end
        if (rtn_err !== e) begin
            $display("FAIL %s err got %b want %b", nm, rtn_err, e);
            bad = 1'b1;
        end
        if (bad) n_bad++;
    endtask

    initial begin
        logic [511:0] junk;

        pk[0] = {3'b101, {15{8'h5A}}};
        pk[1] = {3'b011, {15{8'hC3}}};
        pk[2] = {3'b110, {30{4'h9}}};
        pk[3] = {3'b001, {15{8'h17}}};
        pk[4] = '0;

        //         rst req     ack rtn grant   v  p  cnt   b  e
        tv[0]  = '{0, 4'b0001, 0, 0, 4'b0001, 1, 0, 4'd0, 1, 0};
        tv[1]  = '{0, 4'b0000, 0, 0, 4'b0000, 1, 0, 4'd0, 1, 0};
        tv[2]  = '{0, 4'b0000, 0, 0, 4'b0000, 1, 0, 4'd0, 1, 0};
        tv[3]  = '{0, 4'b0000, 1, 0, 4'b0000, 0, 0, 4'd1, 0, 0};
        tv[4]  = '{1, 4'b1111, 1, 0, 4'b0001, 1, 0, 4'd0, 1, 0};
        tv[5]  = '{0, 4'b1111, 1, 0, 4'b0000, 0, 0, 4'd1, 0, 0};
        tv[6]  = '{0, 4'b1111, 1, 1, 4'b0010, 1, 1, 4'd0, 1, 0};
        tv[7]  = '{0, 4'b1111, 1, 0, 4'b0000, 0, 1, 4'd1, 0, 0};
        tv[8]  = '{0, 4'b1111, 1, 1, 4'b0100, 1, 2, 4'd0, 1, 0};
        tv[9]  = '{0, 4'b1111, 1, 0, 4'b0000, 0, 2, 4'd1, 0, 0};
        tv[10] = '{0, 4'b1111, 1, 1, 4'b1000, 1, 3, 4'd0, 1, 0};
        tv[11] = '{0, 4'b1111, 1, 0, 4'b0000, 0, 3, 4'd1, 0, 0};
        tv[12] = '{0, 4'b1111, 1, 1, 4'b0001, 1, 0, 4'd0, 1, 0};
        tv[13] = '{0, 4'b1111, 1, 0, 4'b0000, 0, 0, 4'd1, 0, 0};
        tv[14] = '{1, 4'b0000, 0, 1, 4'b0000, 0, 4, 4'd0, 0, 1};
        tv[15] = '{0, 4'b0000, 0, 0, 4'b0000, 0, 4, 4'd0, 0, 0};
        tv[16] = '{0, 4'b1111, 0, 0, 4'b0001, 1, 0, 4'd0, 1, 0};
        tv[17] = '{0, 4'b1111, 1, 0, 4'b0000, 0, 0, 4'd1, 0, 0};
        tv[18] = '{0, 4'b1111, 0, 0, 4'b0010, 1, 1, 4'd1, 1, 0};
        tv[19] = '{0, 4'b1111, 1, 0, 4'b0000, 0, 1, 4'd2, 0, 0};
        tv[20] = '{0, 4'b1111, 0, 0, 4'b0100, 1, 2, 4'd2, 1, 0};
        tv[21] = '{0, 4'b1111, 1, 0, 4'b0000, 0, 2, 4'd3, 0, 0};
        tv[22] = '{0, 4'b1111, 0, 0, 4'b1000, 1, 3, 4'd3, 1, 0};
        tv[23] = '{0, 4'b0000, 1, 1, 4'b0000, 0, 3, 4'd3, 0, 0};
        tv[24] = '{0, 4'b0001, 0, 0, 4'b0001, 1, 0, 4'd3, 1, 0};
        tv[25] = '{0, 4'b0000, 1, 0, 4'b0000, 0, 0, 4'd4, 0, 0};

        arst_l           = 1'b0;
        bus.req_vld      = '0;
        bus.lsu_ldst_ack = 1'b0;
        cpx_rtn_vld      = 1'b0;
        drive_pk();
        #3;
        chk("reset", 4'b0000, 1'b0, 4, 4'd0, 1'b0, 1'b0);
        step();
        arst_l = 1'b1;

        for (int i = 0; i < 26; i++) begin
            if (tv[i].rst) do_reset();
            bus.req_vld      = tv[i].req;
            bus.lsu_ldst_ack = tv[i].ack;
            cpx_rtn_vld      = tv[i].rtn;
            step();
            chk($sformatf("vec%0d", i), tv[i].g, tv[i].v,
                tv[i].p, tv[i].c, tv[i].b, tv[i].e);
        end

        // fill the credit pool, then block and recover
        bus.lsu_ldst_ack = 1'b0;
        cpx_rtn_vld      = 1'b0;
        do_reset();
        bus.req_vld = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            bus.lsu_ldst_ack = 1'b0;
            step();
            chk($sformatf("full_g%0d", i), 4'(1 << (i % 4)),
                1'b1, i % 4, 4'(i), 1'b1, 1'b0);
            bus.lsu_ldst_ack = 1'b1;
            step();
            chk($sformatf("full_a%0d", i), 4'b0000, 1'b0,
                i % 4, 4'(i + 1), 1'b0, 1'b0);
        end
        bus.lsu_ldst_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_blk", 4'b0000, 1'b0, 3, 4'd8, 1'b0, 1'b0);
        end
        cpx_rtn_vld = 1'b1;
        step();
        chk("full_rtn", 4'b0000, 1'b0, 3, 4'd7, 1'b0, 1'b0);
        cpx_rtn_vld = 1'b0;
        step();
        chk("full_regr", 4'b0001, 1'b1, 0, 4'd7, 1'b1, 1'b0);
        bus.lsu_ldst_ack = 1'b1;
        step();
        chk("full_ack", 4'b0000, 1'b0, 0, 4'd8, 1'b0, 1'b0);
        bus.lsu_ldst_ack = 1'b0;
        bus.req_vld      = '0;

        // hold packet while inputs churn, then reset mid-send
        do_reset();
        bus.req_vld = 4'b0001;
        step();
        chk("h_g0", 4'b0001, 1'b1, 0, 4'd0, 1'b1, 1'b0);
        bus.req_vld      = 4'b0000;
        bus.lsu_ldst_ack = 1'b1;
        step();
        chk("h_a0", 4'b0000, 1'b0, 0, 4'd1, 1'b0, 1'b0);
        bus.lsu_ldst_ack = 1'b0;
        bus.req_vld      = 4'b0010;
        step();
        chk("h_g1", 4'b0010, 1'b1, 1, 4'd1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            for (int w = 0; w < 16; w++) junk[w*32 +: 32] = $urandom();
            bus.req_pckt = junk[NREQ*PW-1:0];
            bus.req_vld  = 4'($urandom_range(0, 15));
            step();
            chk($sformatf("h_hold%0d", i), 4'b0000, 1'b1, 1,
                4'd1, 1'b1, 1'b0);
        end
        #2;
        arst_l = 1'b0;
        #1;
        chk("h_rst", 4'b0000, 1'b0, 4, 4'd0, 1'b0, 1'b0);
        #1;
        arst_l = 1'b1;
        drive_pk();
        bus.req_vld = 4'b1111;
        step();
        chk("h_first", 4'b0001, 1'b1, 0, 4'd0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/spu_ldst_arb.md
Name: spu_ldst_arb

Overview:
- Round-robin arbiter and sequencer for the SPU→LSU ld/st packet channel.
- Shares the single 123-bit ldst packet path among NREQ SPU requesters (per-thread MA ld/st engines).
- Holds each granted packet stable until the LSU acknowledges it.
- Limits outstanding requests using a credit counter that is replenished by CPX return valids.

Parameters:
- NREQ, 4, number of requesters.
- PW, 123, ldst packet width.
- MAX_OUTST, 8, maximum acked-but-unreturned requests.
- CNTW, 4, width of the outstanding counter; must hold MAX_OUTST.

Ports:
- rclk  in  1  clock.
- arst_l  in  1  reset, asynchronous, active-low.
- req_vld  in  NREQ  per-requester request valid.
- req_pckt  in  NREQ*PW  per-requester packet; requester i occupies bits [i*PW +: PW].
- arb_grant  out  NREQ  one-hot, one-cycle grant pulse.
- ldst_pckt_vld  out  1  packet valid to LSU.
- ldst_pckt  out  PW  registered packet to LSU.
- lsu_ldst_ack  in  1  LSU accepted the current packet.
- cpx_rtn_vld  in  1  CPX return for one outstanding request.
- outst_cnt  out  CNTW  outstanding request count.
- arb_busy  out  1  state != IDLE.
- rtn_err  out  1  one-cycle pulse on credit underflow.

Behaviour:
- Clocking and reset: one clock, rclk. Reset is asynchronous and active-low (arst_l).
- All state and outputs are registered.
- Reset values: state=IDLE, ldst_pckt_vld=0, ldst_pckt=0, arb_grant=0, outst_cnt=0, rtn_err=0, RR pointer last=NREQ-1 (requester 0 has highest priority first).
- Reset asserted mid-SEND drops the packet immediately; a subsequent ack or return is ignored or treated per the rules below.
- FSM states: IDLE, SEND.
- IDLE:
  - Eligible when |req_vld and outst_cnt < MAX_OUTST; uses the registered count only, not same-cycle returns.
  - Winner = first set req_vld scanning from last+1 upward, mod NREQ.
  - At the clock edge: ldst_pckt <= winner's slice; ldst_pckt_vld <= 1; arb_grant <= onehot(winner); last <= winner; state <= SEND.
  - Latency: request sampled in cycle N → grant pulse and packet valid in cycle N+1.
- SEND:
  - ldst_pckt and ldst_pckt_vld are held stable; req_vld and req_pckt are not sampled.
  - arb_grant returns to 0 after one cycle.
  - On lsu_ldst_ack: ldst_pckt_vld <= 0, state <= IDLE. ldst_pckt keeps its last value.
  - Ack arriving in the same cycle the packet first goes valid (N+1) is legal.
  - Next grant is evaluated in IDLE in the cycle after the ack, giving a one-cycle bubble between packets.
- Requester rules:
  - Hold req_vld/req_pckt until grant is seen. A requester may withdraw before grant.
  - On seeing grant, it must drop or advance its request that cycle. The stale req_vld is harmless because the arbiter is in SEND.
- lsu_ldst_ack in IDLE is ignored.
- outst_cnt update, by case:
  - +1 on an accepted ack (SEND & ack).
  - -1 on cpx_rtn_vld.
  - Both in the same cycle: unchanged.
- Underflow: cpx_rtn_vld with outst_cnt==0 and no accepted ack → count stays 0, rtn_err pulses for one cycle.
- Full: when outst_cnt==MAX_OUTST, no grant is issued. A return lowers the count, and a grant is possible in the following cycle.
- A count above MAX_OUTST is unreachable by construction.
- arb_busy = (state==SEND).

Test Plan:
- Reset, then req_vld=4'b0001 with pckt0=0x5A… in cycle N → cycle N+1: arb_grant=0001, ldst_pckt_vld=1, ldst_pckt=pckt0. Ack at N+3 → vld=0 at N+4, outst_cnt=1.
- All four requesters held valid, ack every SEND cycle, cpx_rtn_vld every cycle → grants in order 0,1,2,3,0 with a one-cycle IDLE bubble between each; outst_cnt stays ≤1.
- Eight grants acked with no returns → outst_cnt=8; further req_vld gets no grant. One cpx_rtn_vld → outst_cnt=7, grant issued the next cycle.
- cpx_rtn_vld with outst_cnt=0 → rtn_err=1 for one cycle, count 0. Ack and return in the same cycle at count 3 → count stays 3.
- Packet held for 5 cycles without ack while req_pckt changes → ldst_pckt unchanged throughout. arst_l pulsed low mid-SEND → vld=0 and cnt=0 immediately; after release, requester 0 is granted first.
- Ack in the first valid cycle (N+1) → IDLE at N+2; next packet valid at N+3.
